// File: rtl/mux_pkg.sv
// mux_pkg: shared channel count and index/one-hot types for the round-robin mux
package mux_pkg;
  localparam int N_CH = 4;
  typedef logic [1:0] sel_t;
  typedef logic [N_CH-1:0] onehot_t;
endpackage

// File: rtl/rr_arbiter_4.sv
// rr_arbiter_4: round-robin grant (req, last -> one-hot grant, grant_idx) searching last+1..last
module rr_arbiter_4
  import mux_pkg::*;
(
  input  onehot_t req,
  input  sel_t    last,
  output onehot_t grant,
  output sel_t    grant_idx
);
  logic [7:0] dbl;
  logic [2:0] sh;
  logic [3:0] rot;
  logic [1:0] off;
  always_comb begin
    sh = {1'b0, last} + 3'd1;
    dbl = {req, req} >> sh;
    rot = dbl[3:0];
    off = rot[0] ? 2'd0 : rot[1] ? 2'd1 : rot[2] ? 2'd2 : 2'd3;
    grant_idx = last + 2'd1 + off;
    grant = (|req) ? onehot_t'(4'b1 << grant_idx) : '0;
  end
endmodule

// File: rtl/round_robin_mux_4_1.sv
// round_robin_mux_4_1: 4:1 round-robin mux (in_valid/in_ready/d0..d3 -> registered out_valid/out_data/out_sel, out_ready backpressure)
module round_robin_mux_4_1
  import mux_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_CH-1:0]  in_valid,
  input  logic [WIDTH-1:0] d0,
  input  logic [WIDTH-1:0] d1,
  input  logic [WIDTH-1:0] d2,
  input  logic [WIDTH-1:0] d3,
  output logic [N_CH-1:0]  in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       out_sel,
  input  logic             out_ready
);
  onehot_t grant;
  sel_t grant_idx, last_q, last_d, out_sel_q, out_sel_d;
  logic out_valid_q, out_valid_d, can_load, xfer;
  logic [WIDTH-1:0] out_data_q, out_data_d, sel_data;
  rr_arbiter_4 u_arb (.req(in_valid), .last(last_q), .grant(grant), .grant_idx(grant_idx));
  always_comb begin
    can_load = rst_n & (~out_valid_q | out_ready);
    in_ready = grant & {N_CH{can_load}};
    xfer = |in_ready;
    sel_data = ({WIDTH{grant[0]}} & d0) | ({WIDTH{grant[1]}} & d1) |
               ({WIDTH{grant[2]}} & d2) | ({WIDTH{grant[3]}} & d3);
    out_valid_d = xfer | (out_valid_q & ~out_ready);
    out_data_d = xfer ? sel_data : out_data_q;
    out_sel_d = xfer ? grant_idx : out_sel_q;
    last_d = xfer ? grant_idx : last_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q <= '0;
      out_sel_q <= '0;
      last_q <= 2'd3;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q <= out_data_d;
      out_sel_q <= out_sel_d;
      last_q <= last_d;
    end
  end
  assign out_valid = out_valid_q;
  assign out_data = out_data_q;
  assign out_sel = out_sel_q;
endmodule

// File: tb/tb_round_robin_mux_4_1.sv
// tb_round_robin_mux_4_1: directed and random checks of round_robin_mux_4_1 against a queue-free behavioural model
module tb_round_robin_mux_4_1;
  localparam int WIDTH = 4;
  logic clk = 1'b0;
  logic rst_n;
  logic [3:0] in_valid;
  logic [WIDTH-1:0] d [4];
  logic [3:0] in_ready;
  logic out_valid, out_ready;
  logic [WIDTH-1:0] out_data;
  logic [1:0] out_sel;
  int n_cmp = 0, n_bad = 0;
  logic m_valid;
  logic [WIDTH-1:0] m_data;
  int m_sel, m_last;
  round_robin_mux_4_1 #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid),
    .d0(d[0]), .d1(d[1]), .d2(d[2]), .d3(d[3]),
    .in_ready(in_ready), .out_valid(out_valid), .out_data(out_data),
    .out_sel(out_sel), .out_ready(out_ready)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic model_reset();
    m_valid = 1'b0;
    m_data = '0;
    m_sel = 0;
    m_last = 3;
  endtask
  task automatic step();
    int g;
    logic [3:0] exp_rdy;
    #2;
    g = -1;
    if (!m_valid || out_ready)
      for (int k = 1; k <= 4; k++)
        if (g < 0 && in_valid[(m_last + k) % 4]) g = (m_last + k) % 4;
    exp_rdy = (g < 0) ? 4'b0 : 4'(1 << g);
    check("in_ready", 32'(in_ready), 32'(exp_rdy));
    @(posedge clk);
    if (g >= 0) begin
      m_valid = 1'b1;
      m_data = d[g];
      m_sel = g;
      m_last = g;
    end else if (m_valid && out_ready) m_valid = 1'b0;
    #1;
    check("out_valid", 32'(out_valid), 32'(m_valid));
    check("out_data", 32'(out_data), 32'(m_data));
    check("out_sel", 32'(out_sel), 32'(m_sel));
  endtask
  initial begin
    logic [3:0] exp_seq [5];
    exp_seq[0] = 4'ha; exp_seq[1] = 4'hb; exp_seq[2] = 4'hc; exp_seq[3] = 4'hd; exp_seq[4] = 4'ha;
    rst_n = 1'b0;
    in_valid = 4'b1111;
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) d[i] = 4'(i + 1);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", 32'(in_ready), 32'h0);
    check("rst_out_valid", 32'(out_valid), 32'h0);
    check("rst_out_data", 32'(out_data), 32'h0);
    check("rst_out_sel", 32'(out_sel), 32'h0);
    rst_n = 1'b1;
    in_valid = 4'b1111;
    d[0] = 4'ha; d[1] = 4'hb; d[2] = 4'hc; d[3] = 4'hd;
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      check("rr_seq", 32'(out_data), 32'(exp_seq[i]));
    end
    in_valid = 4'b0100;
    #2 check("single_rdy", 32'(in_ready), 32'b0100);
    step();
    check("single_data", 32'(out_data), 32'hc);
    check("single_sel", 32'(out_sel), 32'd2);
    in_valid = 4'b0010;
    step();
    out_ready = 1'b0;
    in_valid = 4'b1111;
    for (int i = 0; i < 3; i++) begin
      step();
      check("bp_rdy", 32'(in_ready), 32'h0);
      check("bp_data", 32'(out_data), 32'hb);
      check("bp_sel", 32'(out_sel), 32'd1);
    end
    out_ready = 1'b1;
    step();
    check("bp_next_sel", 32'(out_sel), 32'd2);
    in_valid = 4'b1000;
    step();
    in_valid = 4'b1010;
    step();
    check("wrap_sel0", 32'(out_sel), 32'd1);
    step();
    check("wrap_sel1", 32'(out_sel), 32'd3);
    step();
    check("wrap_sel2", 32'(out_sel), 32'd1);
    in_valid = 4'b0001;
    d[3] = 'x;
    d[0] = 4'h7;
    step();
    check("x_iso", 32'(out_data), 32'h7);
    d[3] = 4'hd;
    out_ready = 1'b0;
    in_valid = 4'b0100;
    step();
    check("pre_rst_valid", 32'(out_valid), 32'h1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_valid", 32'(out_valid), 32'h0);
    check("arst_data", 32'(out_data), 32'h0);
    check("arst_sel", 32'(out_sel), 32'h0);
    check("arst_rdy", 32'(in_ready), 32'h0);
    model_reset();
    in_valid = 4'b0000;
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk) #1;
    in_valid = 4'b1111;
    out_ready = 1'b1;
    #2 check("post_rst_first", 32'(in_ready), 32'b0001);
    step();
    for (int i = 0; i < 400; i++) begin
      in_valid = ($urandom_range(0, 4) == 0) ? 4'b0 : 4'($urandom);
      out_ready = ($urandom_range(0, 2) != 0);
      for (int j = 0; j < 4; j++) d[j] = 4'($urandom);
      step();
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/round_robin_mux_4_1.md
ROUND_ROBIN_MUX_4_1 -- requirements
Module: round_robin_mux_4_1

Interface
REQ-001 Parameter: WIDTH, default 4, bit width of every data channel.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 in_valid  input  4  per-channel valid; bit i qualifies d_i.
REQ-005 d0, d1, d2, d3  input  WIDTH each  channel data.
REQ-006 in_ready  output  4  per-channel ready; one-hot or zero.
REQ-007 out_valid  output  1  registered output holds a valid word.
REQ-008 out_data  output  WIDTH  registered selected word.
REQ-009 out_sel  output  2  registered index of the channel that supplied out_data.
REQ-010 out_ready  input  1  downstream accepts the word when high with out_valid.

Function
REQ-011 Transfer on channel i: in_valid[i] & in_ready[i] at a rising edge; output transfer: out_valid & out_ready.
REQ-012 can_load = ~out_valid | out_ready; at most one in_ready bit high per cycle, and only when can_load.
REQ-013 Grant: round-robin among asserted in_valid bits, search order last+1, last+2, last+3, last (mod 4), where last is the most recently accepted channel.
REQ-014 in_ready[i] = grant[i] & can_load; combinational from in_valid, last, out_valid, out_ready; no combinational path from d0..d3.
REQ-015 On an input transfer: out_data <= selected d_i, out_sel <= i, out_valid <= 1, last <= i, all on the same edge.
REQ-016 On an output transfer with no input transfer: out_valid <= 0; out_data and out_sel hold.
REQ-017 Simultaneous output and input transfer: new word loads, out_valid stays 1; sustained throughput one word per cycle.
REQ-018 Latency: word accepted at edge N appears on out_data/out_valid after edge N, consumable at edge N+1.
REQ-019 Backpressure: while out_valid & ~out_ready, out_data, out_sel, out_valid, last are stable and in_ready = 0.
REQ-020 last updates only on input transfer; idle cycles (no in_valid) change no state.
REQ-021 Wrap-around: after last = 3, search begins at channel 0.
REQ-022 Fairness: with all four in_valid held high and out_ready high, out_sel sequence is strictly 0,1,2,3,0,...
REQ-023 X on an unselected d_i shall not propagate to out_data (data path built from AND/OR select, as in the combinational mux family).

Reset
REQ-024 While rst_n = 0: out_valid = 0, out_data = 0, out_sel = 0, last = 3, in_ready = 0; effect immediate, independent of clk.
REQ-025 After rst_n deasserts, first grant priority is channel 0; reset mid-transfer discards the held word with no output transfer.

Structure
REQ-026 Shared package mux_pkg: N_CH = 4, typedef sel_t (2-bit channel index), typedef onehot_t (4-bit one-hot).
REQ-027 One sub-module: rr_arbiter_4 (in: req[3:0], last; out: grant one-hot, grant_idx); state stays in the top.
REQ-028 Data selection uses a 4:1 AND/OR mux driven by the one-hot grant expanded to WIDTH.

Verification
REQ-029 Reset: rst_n = 0 asynchronously mid-cycle with out_valid = 1 -> out_valid, out_data, out_sel, in_ready read 0 before next edge.
REQ-030 Single channel: in_valid = 4'b0100, d2 = 'hc, out_ready = 1 -> in_ready = 4'b0100, next cycle out_data = 'hc, out_sel = 2.
REQ-031 Round-robin: in_valid = 4'b1111, d0..d3 = 'ha,'hb,'hc,'hd, out_ready = 1 -> out_data sequence a,b,c,d,a over 5 cycles after reset.
REQ-032 Backpressure: out_valid = 1 holding 'hb, out_ready = 0 for 3 cycles -> in_ready = 0, out_data = 'hb, out_sel = 1 stable; on out_ready = 1, next grant goes to channel 2 if requesting.
REQ-033 Skip and wrap: last = 3, in_valid = 4'b1010 -> grant channel 1, then channel 3, then channel 1.
REQ-034 X isolation: d3 = 'x, in_valid = 4'b0001, d0 = 7 -> out_data = 7 with no X.
